hazard_stall_unit: RTL and testbench

HAZARD_STALL_UNIT -- requirements
Module: hazard_stall_unit

---
 rtl/hazard_stall_unit.sv | 102 ++++++++++
 tb/tb_hazard_stall_unit.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_unit.sv
// Stall/flush control for the ID stage: load-use and HI/LO occupancy hazards,
// taken-branch flush, and a saturating stall counter.
module hazard_stall_unit #(
    parameter int unsigned MULDIV_LATENCY = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  ID_RegRs,
    input  logic [4:0]  ID_RegRt,
    input  logic        ID_UsesRt,
    input  logic        ID_MulDiv,
    input  logic        ID_ReadsHiLo,
    input  logic        ID_EX_MemRead,
    input  logic [4:0]  ID_EX_RegRt,
    input  logic        EX_BranchTaken,
    output logic        PC_Write,
    output logic        IF_ID_Write,
    output logic        ID_EX_Bubble,
    output logic        IF_ID_Flush,
    output logic        MulDiv_Busy,
    output logic [15:0] Stall_Count
);
    localparam int unsigned CW = $clog2(MULDIV_LATENCY + 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [15:0]    stall_cnt_q, stall_cnt_d;
    logic           load_use, hilo_haz, stall, issue;

    // $0 is hardwired, so a load targeting it never produces a value to wait on.
    assign load_use = ID_EX_MemRead && (ID_EX_RegRt != 5'd0) &&
                      ((ID_RegRs == ID_EX_RegRt) ||
                       (ID_UsesRt && (ID_RegRt == ID_EX_RegRt)));
    assign hilo_haz = (state_q == BUSY) && (ID_ReadsHiLo || ID_MulDiv);
    assign stall    = (load_use || hilo_haz) && !EX_BranchTaken;
    assign issue    = ID_MulDiv && !stall && !EX_BranchTaken;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (issue) begin
                    state_d = BUSY;
                    cnt_d   = CW'(MULDIV_LATENCY);
                end
            end
            BUSY: begin
                // A taken branch does not cancel the in-flight operation.
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Reset holds the front end frozen with a bubble, independent of inputs.
    always_comb begin
        PC_Write     = 1'b1;
        IF_ID_Write  = 1'b1;
        ID_EX_Bubble = 1'b0;
        IF_ID_Flush  = 1'b0;
        if (!rst_n) begin
            PC_Write     = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Bubble = 1'b1;
        end else if (EX_BranchTaken) begin
            ID_EX_Bubble = 1'b1;
            IF_ID_Flush  = 1'b1;
        end else if (stall) begin
            PC_Write     = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Bubble = 1'b1;
        end
    end

    assign MulDiv_Busy = (state_q == BUSY);
    assign Stall_Count = stall_cnt_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Scoreboard bench for hazard_stall_unit with MULDIV_LATENCY=4.
module tb_hazard_stall_unit;
  localparam int LAT = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [4:0] ID_RegRs = '0, ID_RegRt = '0, ID_EX_RegRt = '0;
  logic ID_UsesRt = 0, ID_MulDiv = 0, ID_ReadsHiLo = 0, ID_EX_MemRead = 0, EX_BranchTaken = 0;
  logic PC_Write, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush, MulDiv_Busy;
  logic [15:0] Stall_Count;

  always #5 clk = ~clk;

  hazard_stall_unit #(.MULDIV_LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .ID_RegRs(ID_RegRs), .ID_RegRt(ID_RegRt), .ID_UsesRt(ID_UsesRt),
    .ID_MulDiv(ID_MulDiv), .ID_ReadsHiLo(ID_ReadsHiLo),
    .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_RegRt(ID_EX_RegRt),
    .EX_BranchTaken(EX_BranchTaken),
    .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write), .ID_EX_Bubble(ID_EX_Bubble),
    .IF_ID_Flush(IF_ID_Flush), .MulDiv_Busy(MulDiv_Busy), .Stall_Count(Stall_Count)
  );

  int n_cmp = 0, n_err = 0;
  logic [20:0] sb[$];
  logic [20:0] exp_v;
  int m_busy_left = 0, m_cnt = 0;
  bit m_stall = 0, m_issue = 0;

  function automatic logic [20:0] obs();
    return {PC_Write, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush, MulDiv_Busy, Stall_Count};
  endfunction

  // Apply one cycle of ID/EX inputs and queue the model's expected outputs.
  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                       input logic md, input logic rhl, input logic mr,
                       input logic [4:0] exrt, input logic br);
    bit lu, hz;
    logic [3:0] ctl;
    ID_RegRs = rs; ID_RegRt = rt; ID_UsesRt = urt; ID_MulDiv = md;
    ID_ReadsHiLo = rhl; ID_EX_MemRead = mr; ID_EX_RegRt = exrt; EX_BranchTaken = br;
    lu = mr && (exrt != 0) && ((rs == exrt) || (urt && (rt == exrt)));
    hz = (m_busy_left > 0) && (rhl || md);
    m_stall = (lu || hz) && !br;
    m_issue = md && !m_stall && !br && (m_busy_left == 0);
    if (br) ctl = 4'b1111;
    else if (m_stall) ctl = 4'b0010;
    else ctl = 4'b1100;
    sb.push_back({ctl, (m_busy_left > 0), 16'(m_cnt)});
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    if (m_stall) m_cnt = (m_cnt >= 65535) ? 65535 : m_cnt + 1;
    if (m_busy_left > 0) m_busy_left--;
    else if (m_issue) m_busy_left = LAT;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 0;
    for (int i = 0; i < 3; i++) begin
      drive(8, 8, 1, 1, 1, 1, 8, (i == 1));
      void'(sb.pop_front());
      n_cmp++;
      if (obs() !== {4'b0010, 1'b0, 16'd0}) begin
        n_err++; $display("FAIL reset: got %h want %h", obs(), {4'b0010, 1'b0, 16'd0});
      end
      @(negedge clk);
    end
    m_busy_left = 0; m_cnt = 0; m_stall = 0; m_issue = 0;
    rst_n = 1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    exp_v = sb.pop_front(); n_cmp++;
    if (obs() !== exp_v) begin n_err++; $display("FAIL reset_release: got %h want %h", obs(), exp_v); end
    tick();
  endtask

  task automatic test_load_use();
    drive(8, 10, 1, 0, 0, 1, 8, 0);
    exp_v = sb.pop_front(); n_cmp++;
    if (obs() !== exp_v) begin n_err++; $display("FAIL load_use: got %h want %h", obs(), exp_v); end
    tick();
    drive(8, 10, 1, 0, 0, 0, 0, 0);
    exp_v = sb.pop_front(); n_cmp++;
    if (obs() !== exp_v) begin n_err++; $display("FAIL load_use_next: got %h want %h", obs(), exp_v); end
    n_cmp++;
    if (Stall_Count !== 16'd1) begin n_err++; $display("FAIL load_use_count: got %0d want 1", Stall_Count); end
    tick();
  endtask

  task automatic test_no_hazard();
    // {rs, rt, uses_rt, memread, ex_rt, expect_stall}
    logic [4:0] rs_t[5] = '{0, 3, 3, 8, 7};
    logic [4:0] rt_t[5] = '{5, 8, 8, 0, 0};
    logic       urt_t[5] = '{1, 0, 1, 0, 1};
    logic       mr_t[5] = '{1, 1, 1, 0, 1};
    logic [4:0] ex_t[5] = '{0, 8, 8, 8, 0};
    logic       st_t[5] = '{0, 0, 1, 0, 0};
    for (int i = 0; i < 5; i++) begin
      drive(rs_t[i], rt_t[i], urt_t[i], 0, 0, mr_t[i], ex_t[i], 0);
      exp_v = sb.pop_front(); n_cmp++;
      if (obs() !== exp_v) begin n_err++; $display("FAIL no_hazard[%0d]: got %h want %h", i, obs(), exp_v); end
      n_cmp++;
      if (ID_EX_Bubble !== st_t[i]) begin
        n_err++; $display("FAIL no_hazard_bubble[%0d]: got %b want %b", i, ID_EX_Bubble, st_t[i]);
      end
      tick();
    end
  endtask

  task automatic test_muldiv();
    int stalls = 0, busy = 0;
    int s0;
    bit done = 0;
    s0 = m_cnt;
    drive(0, 0, 0, 1, 0, 0, 0, 0);
    exp_v = sb.pop_front(); n_cmp++;
    if (obs() !== exp_v) begin n_err++; $display("FAIL muldiv_issue: got %h want %h", obs(), exp_v); end
    tick();
    for (int i = 0; i < 10 && !done; i++) begin
      drive(0, 0, 0, 0, 1, 0, 0, 0);
      exp_v = sb.pop_front(); n_cmp++;
      if (obs() !== exp_v) begin n_err++; $display("FAIL muldiv_mflo[%0d]: got %h want %h", i, obs(), exp_v); end
      if (MulDiv_Busy) busy++;
      if (ID_EX_Bubble) stalls++; else done = 1;
      tick();
    end
    n_cmp++;
    if (!done || stalls != 4 || busy != 4) begin
      n_err++; $display("FAIL muldiv_stalls: got stalls=%0d busy=%0d want 4/4", stalls, busy);
    end
    n_cmp++;
    if (Stall_Count !== 16'(s0 + 4)) begin
      n_err++; $display("FAIL muldiv_count: got %0d want %0d", Stall_Count, s0 + 4);
    end
  endtask

  task automatic test_back_to_back();
    int stalls = 0;
    bit done = 0;
    drive(0, 0, 0, 1, 0, 0, 0, 0);
    exp_v = sb.pop_front(); n_cmp++;
    if (obs() !== exp_v) begin n_err++; $display("FAIL b2b_issue: got %h want %h", obs(), exp_v); end
    tick();
    for (int i = 0; i < 10 && !done; i++) begin
      drive(0, 0, 0, 1, 0, 0, 0, 0);
      exp_v = sb.pop_front(); n_cmp++;
      if (obs() !== exp_v) begin n_err++; $display("FAIL b2b_second[%0d]: got %h want %h", i, obs(), exp_v); end
      if (ID_EX_Bubble) stalls++; else done = 1;
      tick();
    end
    n_cmp++;
    if (!done || stalls != 4) begin n_err++; $display("FAIL b2b_stalls: got %0d want 4", stalls); end
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      exp_v = sb.pop_front(); n_cmp++;
      if (obs() !== exp_v) begin n_err++; $display("FAIL b2b_drain[%0d]: got %h want %h", i, obs(), exp_v); end
      tick();
    end
  endtask

  task automatic test_branch();
    logic [15:0] c0;
    c0 = Stall_Count;
    drive(8, 10, 1, 0, 0, 1, 8, 1);
    exp_v = sb.pop_front(); n_cmp++;
    if (obs() !== exp_v) begin n_err++; $display("FAIL branch_lu: got %h want %h", obs(), exp_v); end
    tick();
    n_cmp++;
    if (Stall_Count !== c0) begin n_err++; $display("FAIL branch_count: got %0d want %0d", Stall_Count, c0); end
    drive(0, 0, 0, 1, 0, 0, 0, 0);
    void'(sb.pop_front());
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 0, (i == 1), 0, 0, (i == 0));
      exp_v = sb.pop_front(); n_cmp++;
      if (obs() !== exp_v) begin n_err++; $display("FAIL branch_busy[%0d]: got %h want %h", i, obs(), exp_v); end
      tick();
    end
  endtask

  task automatic test_combined();
    logic [15:0] c0;
    drive(0, 0, 0, 1, 0, 0, 0, 0);
    void'(sb.pop_front());
    tick();
    c0 = Stall_Count;
    drive(8, 0, 0, 0, 1, 1, 8, 0);
    exp_v = sb.pop_front(); n_cmp++;
    if (obs() !== exp_v) begin n_err++; $display("FAIL combined: got %h want %h", obs(), exp_v); end
    tick();
    n_cmp++;
    if (Stall_Count !== c0 + 16'd1) begin
      n_err++; $display("FAIL combined_count: got %0d want %0d", Stall_Count, c0 + 16'd1);
    end
    for (int i = 0; i < 4; i++) begin drive(0, 0, 0, 0, 0, 0, 0, 0); void'(sb.pop_front()); tick(); end
  endtask

  task automatic test_reset_mid_busy();
    drive(0, 0, 0, 1, 0, 0, 0, 0);
    void'(sb.pop_front());
    tick();
    for (int i = 0; i < 2; i++) begin drive(0, 0, 0, 0, 0, 0, 0, 0); void'(sb.pop_front()); tick(); end
    n_cmp++;
    if (MulDiv_Busy !== 1'b1) begin n_err++; $display("FAIL rst_mid_pre: got busy %b want 1", MulDiv_Busy); end
    rst_n = 0;
    #1;
    n_cmp++;
    if (obs() !== {4'b0010, 1'b0, 16'd0}) begin
      n_err++; $display("FAIL rst_mid: got %h want %h", obs(), {4'b0010, 1'b0, 16'd0});
    end
    m_busy_left = 0; m_cnt = 0; m_stall = 0; m_issue = 0;
    @(negedge clk);
    rst_n = 1;
    drive(0, 0, 0, 0, 1, 0, 0, 0);
    exp_v = sb.pop_front(); n_cmp++;
    if (obs() !== exp_v) begin n_err++; $display("FAIL rst_mid_release: got %h want %h", obs(), exp_v); end
    tick();
  endtask

  task automatic test_saturate();
    drive(9, 0, 0, 0, 0, 1, 9, 0);
    exp_v = sb.pop_front(); n_cmp++;
    if (obs() !== exp_v) begin n_err++; $display("FAIL sat_start: got %h want %h", obs(), exp_v); end
    for (int i = 0; i < 70000; i++) begin
      @(posedge clk);
      m_cnt = (m_cnt >= 65535) ? 65535 : m_cnt + 1;
    end
    @(negedge clk);
    drive(9, 0, 0, 0, 0, 1, 9, 0);
    exp_v = sb.pop_front(); n_cmp++;
    if (obs() !== exp_v) begin n_err++; $display("FAIL sat_end: got %h want %h", obs(), exp_v); end
    n_cmp++;
    if (Stall_Count !== 16'hFFFF) begin n_err++; $display("FAIL sat_value: got %h want ffff", Stall_Count); end
    tick();
    n_cmp++;
    if (Stall_Count !== 16'hFFFF) begin n_err++; $display("FAIL sat_hold: got %h want ffff", Stall_Count); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_load_use();
    test_no_hazard();
    test_muldiv();
    test_back_to_back();
    test_branch();
    test_combined();
    test_reset_mid_busy();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
